// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory fetch bus between the fetch sequencer and imem.
// One request at a time: req/ready to issue, rvalid/rdata to return.
interface fetch_pc_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch-stage side: issues requests, receives instruction words.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Instruction-memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// Holds the architectural PC, fetches one word at a time, presents it to
// decode, and handles stalls, taken-branch redirects (dropping a stale
// in-flight fetch) and misaligned-target traps.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [31:0]            PC,
    input  logic [31:0]            NexttoPC,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   stall,
    fetch_pc_ctrl_if.master        imem,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic                   instr_valid,
    output logic                   misaligned
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t state;
    state_t nextState;
    logic   discard;
    logic   discardNext;

    // Redirects are ignored before the first request and once trapped.
    logic redirect;
    logic badTarget;
    logic loadTarget;
    logic advancePc;
    logic capture;
    logic flushInstr;
    logic trap;

    assign redirect  = branch_taken && (state != BOOT) && (state != HALT);
    assign badTarget = (branch_target[1:0] != 2'b00);

    // State register and the stale-fetch discard flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            discard <= 1'b0;
        end else begin
            state   <= nextState;
            discard <= discardNext;
        end
    end

    // Next state plus datapath strobes; a redirect outranks stall and the
    // normal sequencing.
    always_comb begin
        nextState   = state;
        discardNext = discard;
        loadTarget  = 1'b0;
        advancePc   = 1'b0;
        capture     = 1'b0;
        flushInstr  = 1'b0;
        trap        = 1'b0;
        if (redirect && badTarget) begin
            trap      = 1'b1;
            nextState = HALT;
        end else if (redirect) begin
            loadTarget = 1'b1;
            flushInstr = 1'b1;
            case (state)
                REQ: begin
                    // An accepted request now fetches the old address.
                    if (imem.imem_ready) begin
                        nextState   = WAIT;
                        discardNext = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        nextState   = REQ;
                        discardNext = 1'b0;
                    end else begin
                        discardNext = 1'b1;
                    end
                end
                ISSUE:   nextState = REQ;
                default: nextState = state;
            endcase
        end else begin
            case (state)
                BOOT: nextState = REQ;
                REQ: begin
                    if (imem.imem_ready) nextState = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (discard) begin
                            discardNext = 1'b0;
                            nextState   = REQ;
                        end else begin
                            capture   = 1'b1;
                            nextState = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        advancePc = 1'b1;
                        nextState = REQ;
                    end
                end
                HALT:    nextState = HALT;
                default: nextState = BOOT;
            endcase
        end
    end

    // Bus and decode-facing outputs decoded from the current state.
    always_comb begin
        imem.imem_req  = (state == REQ);
        imem.imem_addr = PC;
        instr_valid    = (state == ISSUE);
    end

    // PC, presented instruction and sticky trap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC         <= RESET_PC;
            instr      <= NOP_INSTR;
            instr_pc   <= 32'h0000_0000;
            misaligned <= 1'b0;
        end else begin
            if (trap) begin
                misaligned <= 1'b1;
            end
            if (loadTarget) begin
                PC <= branch_target;
            end else if (advancePc) begin
                PC <= NexttoPC;
            end
            if (flushInstr) begin
                instr <= NOP_INSTR;
            end else if (capture) begin
                instr    <= imem.imem_rdata;
                instr_pc <= PC;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomized bench for fetch_pc_ctrl: a driver plays imem and decode, an
// architectural model predicts the sequence of presented instructions, and a
// negedge monitor checks every cycle against it.
module tb_fetch_pc_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PC;
    logic [31:0] NexttoPC;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        misaligned;

    fetch_pc_ctrl_if imemBus();

    fetch_pc_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC           (PC),
        .NexttoPC     (NexttoPC),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .imem         (imemBus),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    // External pc_plus_4 adder.
    assign NexttoPC = PC + 32'd4;

    int total = 0;
    int bad   = 0;

    // Architectural model: PC, trap state, expected next presentations.
    logic [31:0] archPc;
    bit          halted;
    logic [31:0] expQ[$];

    // Effects of the inputs driven for the coming edge.
    bit          pendBranch;
    bit          pendAccept;
    logic [31:0] pendTarget;

    // imem model state.
    bit          outstanding;
    int unsigned lat;
    logic [31:0] faddr;

    // Stimulus knobs.
    int unsigned readyPct;
    int unsigned maxLat;
    int unsigned stallPct;
    int unsigned branchPct;
    bit          forceValid;
    logic [31:0] forceTarget;
    int          cyc;

    // Monitor bookkeeping.
    int          sinceRst;
    int          firstReq;
    int          firstValid;
    int          nPresent;
    bit          prevValid;
    logic [31:0] curPc;
    logic [31:0] lastPresented;
    bit          wrapSeen;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[7:0], a[31:24], a[15:8], a[23:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle, compare DUT-visible state with the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            sinceRst   = 0;
            firstReq   = 0;
            firstValid = 0;
            prevValid  = 1'b0;
        end else begin
            sinceRst++;
            if (imemBus.imem_req && firstReq == 0) firstReq = sinceRst;
            if (instr_valid && firstValid == 0) firstValid = sinceRst;
            chk("pc", PC, archPc);
            chk("imem_addr", imemBus.imem_addr, archPc);
            chk("misaligned", 32'(misaligned), 32'(halted));
            if (halted) begin
                chk("halt_req", 32'(imemBus.imem_req), 32'd0);
                chk("halt_valid", 32'(instr_valid), 32'd0);
            end
            if (instr_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_instr actual_pc=%h required=none", instr_pc);
                end else begin
                    curPc = expQ.pop_front();
                    nPresent++;
                    if (curPc == 32'h0 && lastPresented == 32'hFFFF_FFFC) wrapSeen = 1'b1;
                    lastPresented = curPc;
                end
            end
            if (instr_valid) begin
                chk("instr_pc", instr_pc, curPc);
                chk("instr", instr, memWord(curPc));
            end
            prevValid = instr_valid;
        end
    end

    // One cycle of imem + decode stimulus, after updating the model for the
    // edge just taken.
    task automatic step();
        logic [31:0] r;
        bit          br;
        @(posedge clk);
        #1;
        cyc++;
        if (pendBranch) begin
            expQ.delete();
            if (pendTarget[1:0] != 2'b00) begin
                halted = 1'b1;
                chk("trap_valid", 32'(instr_valid), 32'd0);
            end else begin
                archPc = pendTarget;
                expQ.push_back(archPc);
                chk("flush_nop", instr, NOP);
                chk("flush_valid", 32'(instr_valid), 32'd0);
            end
        end else if (pendAccept) begin
            archPc = archPc + 32'd4;
            expQ.push_back(archPc);
        end
        pendBranch = 1'b0;
        pendAccept = 1'b0;

        imemBus.imem_rvalid = 1'b0;
        imemBus.imem_rdata  = $urandom;
        if (outstanding) begin
            if (lat == 0) begin
                imemBus.imem_rvalid = 1'b1;
                imemBus.imem_rdata  = memWord(faddr);
                outstanding = 1'b0;
            end else begin
                lat--;
            end
        end
        imemBus.imem_ready = ($urandom_range(99, 0) < readyPct);
        if (imemBus.imem_req) begin
            chk("one_outstanding", 32'(outstanding), 32'd0);
            if (imemBus.imem_ready) begin
                outstanding = 1'b1;
                faddr       = imemBus.imem_addr;
                lat         = $urandom_range(maxLat, 0);
            end
        end

        stall = ($urandom_range(99, 0) < stallPct);
        br = 1'b0;
        branch_target = $urandom;
        if (!halted && cyc >= 2) begin
            if (forceValid) begin
                br = 1'b1;
                branch_target = forceTarget;
                forceValid = 1'b0;
            end else if ($urandom_range(99, 0) < branchPct) begin
                br = 1'b1;
                r = $urandom;
                branch_target = (r[4:0] == 5'd0) ? 32'hFFFF_FFF8 : {20'h0, r[11:2], 2'b00};
            end
        end
        branch_taken = br;
        pendBranch   = br;
        pendTarget   = branch_target;
        pendAccept   = !br && instr_valid && !stall;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        imemBus.imem_ready  = 1'b0;
        imemBus.imem_rvalid = 1'b0;
        imemBus.imem_rdata  = 32'h0;
        archPc = RST_PC;
        halted = 1'b0;
        expQ.delete();
        expQ.push_back(RST_PC);
        pendBranch = 1'b0;
        pendAccept = 1'b0;
        outstanding = 1'b0;
        forceValid = 1'b0;
        nPresent = 0;
        wrapSeen = 1'b0;
        lastPresented = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imemBus.imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_pc", PC, RST_PC);
        rst_n = 1'b1;
        cyc = 1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] heldPc;
        imemBus.imem_ready  = 1'b0;
        imemBus.imem_rvalid = 1'b0;
        imemBus.imem_rdata  = 32'h0;
        archPc = RST_PC;
        halted = 1'b0;
        curPc = 32'h0;

        // Zero-wait imem, no stall: first-fetch timing and throughput.
        readyPct = 100; maxLat = 0; stallPct = 0; branchPct = 0;
        doReset();
        runCycles(30);
        chk("first_req_cycle", 32'(firstReq), 32'd2);
        chk("first_valid_cycle", 32'(firstValid), 32'd4);
        chk("zero_wait_count", 32'(nPresent >= 9), 32'd1);

        // Random backpressure, latency, stalls and redirects.
        readyPct = 60; maxLat = 3; stallPct = 35; branchPct = 8;
        runCycles(3000);
        chk("random_progress", 32'(nPresent >= 150), 32'd1);

        // Wrap through 0xFFFF_FFFC with heavy backpressure; the
        // mid-fetch reset here also abandons whatever was outstanding.
        doReset();
        readyPct = 30; maxLat = 2; stallPct = 20; branchPct = 0;
        forceTarget = 32'hFFFF_FFF8;
        forceValid = 1'b1;
        runCycles(200);
        chk("wrap_seen", 32'(wrapSeen), 32'd1);

        // Misaligned redirect: sticky trap until reset.
        doReset();
        readyPct = 70; maxLat = 2; stallPct = 30; branchPct = 5;
        runCycles(300);
        forceTarget = 32'h0000_0202;
        forceValid = 1'b1;
        heldPc = archPc;
        runCycles(1);
        runCycles(30);
        chk("trap_flag", 32'(misaligned), 32'd1);
        chk("trap_pc_hold", PC, heldPc);
        chk("trap_req", 32'(imemBus.imem_req), 32'd0);
        doReset();
        runCycles(20);
        chk("post_trap_progress", 32'(nPresent >= 3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
